// File: rtl/aux_mem_scan_loader_pkg.sv
// Shared widths and FSM encoding for the aux memory scan loader.
// Word width / address width defaults match the 8x256 aux block RAM.
package aux_mem_scan_loader_pkg;

  localparam int AUXL_DW = 8;
  localparam int AUXL_AW = 8;

  typedef enum logic [2:0] {
    AUXL_ST_IDLE     = 3'd0,
    AUXL_ST_LD_SHIFT = 3'd1,
    AUXL_ST_LD_WRITE = 3'd2,
    AUXL_ST_UL_READ  = 3'd3,
    AUXL_ST_UL_WAIT  = 3'd4,
    AUXL_ST_UL_SHIFT = 3'd5,
    AUXL_ST_FIN      = 3'd6
  } auxl_state_e;

endpackage

// File: rtl/aux_mem_scan_loader_shifter.sv
// Serial<->parallel word register: right-shifts serial bits in at the MSB (so the
// first bit lands in bit 0 after DW shifts) or parallel-loads a word to be shifted out LSB first.
module aux_mem_scan_loader_shifter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] load_dat,
  input  logic          shift,
  input  logic          ser_in,
  output logic [DW-1:0] par_dat,
  output logic          bit_last
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic [CW-1:0] bit_cnt;

  assign bit_last = (bit_cnt == CW'(DW - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_dat <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (load) begin
      par_dat <= load_dat;
      bit_cnt <= '0;
    end else if (shift) begin
      par_dat <= {ser_in, par_dat[DW-1:1]};
      bit_cnt <= bit_last ? '0 : bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/aux_mem_scan_loader.sv
// Scan LOAD/UNLOAD front-end for the aux block RAM: LOAD costs DW+1 cycles per word
// (scan_en may stall), UNLOAD streams DW bits per word with a 2-cycle gap and no stall.
module aux_mem_scan_loader
  import aux_mem_scan_loader_pkg::*;
#(
  parameter int DW = AUXL_DW,
  parameter int AW = AUXL_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic          unload_req,
  input  logic [AW:0]   num_words,
  input  logic          scan_en,
  input  logic          scan_in,
  output logic          scan_out,
  output logic          scan_out_vld,
  output logic          busy,
  output logic          done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  auxl_state_e   state, state_nxt;
  logic [AW-1:0] word_cnt;
  logic [AW-1:0] last_idx;
  logic [AW:0]   nw_clamped;
  logic          req_go;
  logic          sh_clr, sh_load, sh_shift, sh_ser_in, bit_last;
  logic [DW-1:0] sh_dat;
  logic          word_adv;

  assign nw_clamped = (num_words > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_words;
  assign req_go     = (state == AUXL_ST_IDLE) && (load_req || unload_req);
  assign word_adv   = ((state == AUXL_ST_LD_WRITE) && (state_nxt == AUXL_ST_LD_SHIFT)) ||
                      ((state == AUXL_ST_UL_SHIFT) && (state_nxt == AUXL_ST_UL_READ));

  // The word counter doubles as the memory address register.
  assign mem_addr  = word_cnt;
  assign mem_wdata = sh_dat;

  aux_mem_scan_loader_shifter #(.DW(DW)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clr      (sh_clr),
    .load     (sh_load),
    .load_dat (mem_rdata),
    .shift    (sh_shift),
    .ser_in   (sh_ser_in),
    .par_dat  (sh_dat),
    .bit_last (bit_last)
  );

  always_comb begin
    state_nxt = state;
    sh_clr    = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_ser_in = 1'b0;
    case (state)
      AUXL_ST_IDLE: begin
        if (load_req || unload_req) begin
          sh_clr = 1'b1;
          if (num_words == '0)   state_nxt = AUXL_ST_FIN;
          else if (load_req)     state_nxt = AUXL_ST_LD_SHIFT;
          else                   state_nxt = AUXL_ST_UL_READ;
        end
      end
      AUXL_ST_LD_SHIFT: begin
        if (scan_en) begin
          sh_shift  = 1'b1;
          sh_ser_in = scan_in;
          if (bit_last) state_nxt = AUXL_ST_LD_WRITE;
        end
      end
      AUXL_ST_LD_WRITE: begin
        state_nxt = (word_cnt == last_idx) ? AUXL_ST_FIN : AUXL_ST_LD_SHIFT;
      end
      AUXL_ST_UL_READ: begin
        state_nxt = AUXL_ST_UL_WAIT;
      end
      AUXL_ST_UL_WAIT: begin
        sh_load   = 1'b1;
        state_nxt = AUXL_ST_UL_SHIFT;
      end
      AUXL_ST_UL_SHIFT: begin
        sh_shift = 1'b1;
        if (bit_last) state_nxt = (word_cnt == last_idx) ? AUXL_ST_FIN : AUXL_ST_UL_READ;
      end
      AUXL_ST_FIN: begin
        state_nxt = AUXL_ST_IDLE;
      end
      default: begin
        state_nxt = AUXL_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= AUXL_ST_IDLE;
      word_cnt     <= '0;
      last_idx     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_we       <= 1'b0;
      scan_out     <= 1'b0;
      scan_out_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_go) begin
        word_cnt <= '0;
        last_idx <= AW'(nw_clamped - 1'b1);
      end else if (word_adv) begin
        word_cnt <= word_cnt + AW'(1);
      end
      busy         <= (state_nxt != AUXL_ST_IDLE) || (state == AUXL_ST_FIN);
      done         <= (state == AUXL_ST_FIN);
      mem_we       <= (state_nxt == AUXL_ST_LD_WRITE);
      scan_out_vld <= (state_nxt == AUXL_ST_UL_SHIFT);
      // Present the bit that will be at par_dat[0] after this edge.
      if (state_nxt == AUXL_ST_UL_SHIFT)
        scan_out <= (state == AUXL_ST_UL_WAIT) ? mem_rdata[0] : sh_dat[1];
      else
        scan_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aux_mem_scan_loader.sv
// Directed bench for aux_mem_scan_loader with a registered-read 8x256 memory model.
module tb_aux_mem_scan_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_req = 1'b0, unload_req = 1'b0;
  logic [8:0] num_words = '0;
  logic       scan_en = 1'b0, scan_in = 1'b0;
  logic       scan_out, scan_out_vld, busy, done, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0, pre_dat = '0;
  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];
  logic       bitq[$];
  int         bitcyc[$];
  logic [7:0] stim [256];

  typedef struct {
    logic [8:0] nw;
    int         n;
    bit         toggle;
    bit         both_req;
    logic [7:0] d0, d1, d2;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  aux_mem_scan_loader dut (
    .clk(clk), .rst(rst), .load_req(load_req), .unload_req(unload_req),
    .num_words(num_words), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(scan_out), .scan_out_vld(scan_out_vld), .busy(busy), .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end
      if (done) done_cnt++;
      if (scan_out_vld) begin
        bitq.push_back(scan_out);
        bitcyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    bitq.delete();
    bitcyc.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_load(input logic [8:0] nw, input int n, input bit toggle, input bit both);
    @(negedge clk);
    load_req = 1'b1; unload_req = both; num_words = nw;
    @(negedge clk);
    load_req = 1'b0; unload_req = 1'b0;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 8; b++) begin
        if (toggle) begin
          scan_en = 1'b0; scan_in = 1'b1;
          @(negedge clk);
        end
        scan_en = 1'b1;
        scan_in = stim[w][b];
        @(negedge clk);
      end
      scan_en = 1'b0;
      scan_in = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic unload_check(input string name, input logic [8:0] nw, input int n);
    int bad;
    clear_logs();
    @(negedge clk);
    unload_req = 1'b1; num_words = nw;
    @(negedge clk);
    unload_req = 1'b0;
    wait_done(name, n * 12 + 20);
    chk({name, "_nbits"}, bitq.size(), n * 8);
    bad = 0;
    for (int i = 0; i < n * 8 && i < bitq.size(); i++)
      if (bitq[i] !== stim[i / 8][i % 8]) bad++;
    chk({name, "_bits_bad"}, bad, 0);
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_no_write"}, wr_addr.size(), 0);
  endtask

  initial begin
    int bad;
    vecs[0] = '{nw: 9'd2, n: 2, toggle: 1'b0, both_req: 1'b0, d0: 8'hA5, d1: 8'h3C, d2: 8'h00};
    vecs[1] = '{nw: 9'd2, n: 2, toggle: 1'b1, both_req: 1'b0, d0: 8'hA5, d1: 8'h3C, d2: 8'h00};
    vecs[2] = '{nw: 9'd1, n: 1, toggle: 1'b0, both_req: 1'b1, d0: 8'hC3, d1: 8'h00, d2: 8'h00};
    vecs[3] = '{nw: 9'd3, n: 3, toggle: 1'b1, both_req: 1'b0, d0: 8'h01, d1: 8'h80, d2: 8'h5A};

    // Reset state
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_vld", {31'd0, scan_out_vld}, 0);
    chk("rst_addr", {24'd0, mem_addr}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset mid-LD_SHIFT after three bits
    clear_logs();
    @(negedge clk);
    load_req = 1'b1; num_words = 9'd2;
    @(negedge clk);
    load_req = 1'b0;
    repeat (3) begin
      scan_en = 1'b1; scan_in = 1'b1;
      @(negedge clk);
    end
    scan_en = 1'b0;
    chk("mid_busy_before", {31'd0, busy}, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_wdata", {24'd0, mem_wdata}, 0);
    chk("mid_rst_addr", {24'd0, mem_addr}, 0);
    chk("mid_rst_out", {29'd0, scan_out, scan_out_vld, mem_we}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    stim[0] = 8'h5A;
    drive_load(9'd1, 1, 1'b0, 1'b0);
    wait_done("mid_reload", 40);
    chk("mid_reload_nwr", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      chk("mid_reload_addr", {24'd0, wr_addr[0]}, 0);
      chk("mid_reload_data", {24'd0, wr_data[0]}, 32'h5A);
    end

    // Table-driven loads, each read back by unload
    foreach (vecs[v]) begin
      clear_logs();
      stim[0] = vecs[v].d0; stim[1] = vecs[v].d1; stim[2] = vecs[v].d2;
      drive_load(vecs[v].nw, vecs[v].n, vecs[v].toggle, vecs[v].both_req);
      wait_done($sformatf("ld%0d", v), 30);
      chk($sformatf("ld%0d_nwr", v), wr_addr.size(), vecs[v].n);
      for (int i = 0; i < vecs[v].n && i < wr_addr.size(); i++) begin
        chk($sformatf("ld%0d_addr%0d", v, i), {24'd0, wr_addr[i]}, i);
        chk($sformatf("ld%0d_data%0d", v, i), {24'd0, wr_data[i]}, {24'd0, stim[i]});
      end
      chk($sformatf("ld%0d_done_cnt", v), done_cnt, 1);
      chk($sformatf("ld%0d_busy_after", v), {31'd0, busy}, 0);
      chk($sformatf("ld%0d_no_vld", v), bitq.size(), 0);
      unload_check($sformatf("ul%0d", v), vecs[v].nw, vecs[v].n);
    end

    // Preloaded unload: exact stream and inter-word gap
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 8'd0; pre_dat = 8'hA5;
    @(negedge clk);
    pre_addr = 8'd1; pre_dat = 8'h3C;
    @(negedge clk);
    pre_we = 1'b0;
    stim[0] = 8'hA5; stim[1] = 8'h3C;
    unload_check("ul_pre", 9'd2, 2);
    begin
      logic [15:0] exp_stream;
      exp_stream = 16'b0011110010100101;
      bad = 0;
      for (int i = 0; i < 16 && i < bitq.size(); i++)
        if (bitq[i] !== exp_stream[i]) bad++;
      chk("ul_pre_stream_bad", bad, 0);
    end
    if (bitcyc.size() == 16) begin
      chk("ul_pre_word_span", bitcyc[7] - bitcyc[0], 7);
      chk("ul_pre_gap", bitcyc[8] - bitcyc[7], 3);
    end else begin
      chk("ul_pre_bitcyc_size", bitcyc.size(), 16);
    end

    // num_words == 0: done two cycles after req, no memory access
    clear_logs();
    @(negedge clk);
    load_req = 1'b1; num_words = 9'd0;
    @(negedge clk);
    load_req = 1'b0;
    chk("nw0_busy_c1", {31'd0, busy}, 1);
    chk("nw0_done_c1", {31'd0, done}, 0);
    @(negedge clk);
    chk("nw0_done_c2", {31'd0, done}, 1);
    @(negedge clk);
    chk("nw0_done_c3", {31'd0, done}, 0);
    chk("nw0_busy_c3", {31'd0, busy}, 0);
    chk("nw0_no_write", wr_addr.size(), 0);
    chk("nw0_done_cnt", done_cnt, 1);

    // Clamped full-depth load and readback
    clear_logs();
    for (int i = 0; i < 256; i++) stim[i] = 8'(i * 37 + 11);
    drive_load(9'h1FF, 256, 1'b0, 1'b0);
    wait_done("ld256", 30);
    chk("ld256_nwr", wr_addr.size(), 256);
    if (wr_addr.size() > 0) chk("ld256_last_addr", {24'd0, wr_addr[wr_addr.size() - 1]}, 32'hFF);
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 256; i++)
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== stim[i]) bad++;
    chk("ld256_bad_words", bad, 0);
    chk("ld256_done_cnt", done_cnt, 1);
    unload_check("ul256", 9'h1FF, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
